nios2_mult_pipe: RTL

Parametrised pipelined integer multiplier for the Nios II-class CPU execute/memory path. It covers MUL, MULXUU, MULXSU and MULXSS for any supported operand width. The block splits the operands into half-width slices and forms four registered unsigned partial products. A sign-correction and accumulate stage then produces the result. It adds a valid/ready handshake, backpressure, a pipeline flush and a destination tag.

---
 rtl/nios2_mult_pkg.sv | 26 ++
 rtl/nios2_mult_pp_cell.sv | 38 +++
 rtl/nios2_mult_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mult_pkg
// Purpose  : Shared op encoding and elaboration helpers for nios2_mult_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package nios2_mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } mult_op_e;

    // Edges from acceptance to out_valid when the pipe is not stalled.
    function automatic int latency(input int out_reg);
        return 2 + ((out_reg != 0) ? 1 : 0);
    endfunction

    function automatic bit data_w_legal(input int data_w);
        return (data_w == 16) || (data_w == 32) || (data_w == 64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_mult_pp_cell.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mult_pp_cell
// Purpose  : Registered unsigned W x W multiply with clock enable (DSP slice).
// Revision : 1.0 - initial release
// ============================================================================
module nios2_mult_pp_cell
    import nios2_mult_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] w_p_d;

    always_comb begin
        w_p_d = p;
        if (en) begin
            w_p_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
        end else begin
            p <= w_p_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mult_pipe
// Purpose  : Pipelined MUL/MULXUU/MULXSU/MULXSS unit with valid/ready, flush
//            and tag; four half-width unsigned products plus sign correction.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_mult_pipe
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int c_half_w = DATA_W / 2;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("nios2_mult_pipe: DATA_W must be 16, 32 or 64");
    end

    logic w_en;
    logic w_accept;

    // One enable for every stage: the pipe only moves when the output slot frees.
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;
    assign w_accept = in_valid & w_en & ~kill;

    // ---------------- S1: operand register ----------------
    logic              r_v1_q,   w_v1_d;
    logic [DATA_W-1:0] r_a1_q,   w_a1_d;
    logic [DATA_W-1:0] r_b1_q,   w_b1_d;
    mult_op_e          r_op1_q,  w_op1_d;
    logic [TAG_W-1:0]  r_tag1_q, w_tag1_d;

    always_comb begin
        w_v1_d   = r_v1_q;
        w_a1_d   = r_a1_q;
        w_b1_d   = r_b1_q;
        w_op1_d  = r_op1_q;
        w_tag1_d = r_tag1_q;
        if (w_en) begin
            w_v1_d   = w_accept;
            w_a1_d   = in_a;
            w_b1_d   = in_b;
            w_op1_d  = mult_op_e'(in_op);
            w_tag1_d = in_tag;
        end
        if (kill) begin
            w_v1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1_q   <= 1'b0;
            r_a1_q   <= '0;
            r_b1_q   <= '0;
            r_op1_q  <= OP_MUL;
            r_tag1_q <= '0;
        end else begin
            r_v1_q   <= w_v1_d;
            r_a1_q   <= w_a1_d;
            r_b1_q   <= w_b1_d;
            r_op1_q  <= w_op1_d;
            r_tag1_q <= w_tag1_d;
        end
    end

    // ---------------- S2: partial products ----------------
    logic [DATA_W-1:0] r_pp_ll_q, r_pp_lh_q, r_pp_hl_q, r_pp_hh_q;

    nios2_mult_pp_cell #(.W(c_half_w)) u_pp_ll (
        .clk(clk), .reset(reset), .en(w_en),
        .a(r_a1_q[c_half_w-1:0]), .b(r_b1_q[c_half_w-1:0]), .p(r_pp_ll_q)
    );
    nios2_mult_pp_cell #(.W(c_half_w)) u_pp_lh (
        .clk(clk), .reset(reset), .en(w_en),
        .a(r_a1_q[c_half_w-1:0]), .b(r_b1_q[DATA_W-1:c_half_w]), .p(r_pp_lh_q)
    );
    nios2_mult_pp_cell #(.W(c_half_w)) u_pp_hl (
        .clk(clk), .reset(reset), .en(w_en),
        .a(r_a1_q[DATA_W-1:c_half_w]), .b(r_b1_q[c_half_w-1:0]), .p(r_pp_hl_q)
    );
    nios2_mult_pp_cell #(.W(c_half_w)) u_pp_hh (
        .clk(clk), .reset(reset), .en(w_en),
        .a(r_a1_q[DATA_W-1:c_half_w]), .b(r_b1_q[DATA_W-1:c_half_w]), .p(r_pp_hh_q)
    );

    logic              r_v2_q,   w_v2_d;
    logic [DATA_W-1:0] r_a2_q,   w_a2_d;
    logic [DATA_W-1:0] r_b2_q,   w_b2_d;
    mult_op_e          r_op2_q,  w_op2_d;
    logic [TAG_W-1:0]  r_tag2_q, w_tag2_d;
    logic              r_as2_q,  w_as2_d;
    logic              r_bs2_q,  w_bs2_d;

    always_comb begin
        w_v2_d   = r_v2_q;
        w_a2_d   = r_a2_q;
        w_b2_d   = r_b2_q;
        w_op2_d  = r_op2_q;
        w_tag2_d = r_tag2_q;
        w_as2_d  = r_as2_q;
        w_bs2_d  = r_bs2_q;
        if (w_en) begin
            w_v2_d   = r_v1_q;
            w_a2_d   = r_a1_q;
            w_b2_d   = r_b1_q;
            w_op2_d  = r_op1_q;
            w_tag2_d = r_tag1_q;
            w_as2_d  = r_a1_q[DATA_W-1];
            w_bs2_d  = r_b1_q[DATA_W-1];
        end
        if (kill) begin
            w_v2_d = 1'b0;
        end
    end

    // S2 data is reset too so the combinational output path reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2_q   <= 1'b0;
            r_a2_q   <= '0;
            r_b2_q   <= '0;
            r_op2_q  <= OP_MUL;
            r_tag2_q <= '0;
            r_as2_q  <= 1'b0;
            r_bs2_q  <= 1'b0;
        end else begin
            r_v2_q   <= w_v2_d;
            r_a2_q   <= w_a2_d;
            r_b2_q   <= w_b2_d;
            r_op2_q  <= w_op2_d;
            r_tag2_q <= w_tag2_d;
            r_as2_q  <= w_as2_d;
            r_bs2_q  <= w_bs2_d;
        end
    end

    // ---------------- S3: accumulate, sign-correct, select ----------------
    logic [2*DATA_W-1:0] w_sum;
    logic [2*DATA_W-1:0] w_corr_a;
    logic [2*DATA_W-1:0] w_corr_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_result;

    always_comb begin
        w_sum = {{DATA_W{1'b0}}, r_pp_ll_q}
              + ({{DATA_W{1'b0}}, r_pp_lh_q} << c_half_w)
              + ({{DATA_W{1'b0}}, r_pp_hl_q} << c_half_w)
              + {r_pp_hh_q, {DATA_W{1'b0}}};
        w_corr_a = '0;
        w_corr_b = '0;
        // Two's-complement operand = unsigned value - sign * 2^DATA_W.
        if (r_as2_q && (r_op2_q == OP_MULXSU || r_op2_q == OP_MULXSS)) begin
            w_corr_a = {r_b2_q, {DATA_W{1'b0}}};
        end
        if (r_bs2_q && (r_op2_q == OP_MULXSS)) begin
            w_corr_b = {r_a2_q, {DATA_W{1'b0}}};
        end
        w_prod   = w_sum - w_corr_a - w_corr_b;
        w_result = (r_op2_q == OP_MUL) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              r_out_valid_q,  w_out_valid_d;
        logic [DATA_W-1:0] r_out_result_q, w_out_result_d;
        logic [TAG_W-1:0]  r_out_tag_q,    w_out_tag_d;

        always_comb begin
            w_out_valid_d  = r_out_valid_q;
            w_out_result_d = r_out_result_q;
            w_out_tag_d    = r_out_tag_q;
            if (w_en) begin
                w_out_valid_d  = r_v2_q;
                w_out_result_d = w_result;
                w_out_tag_d    = r_tag2_q;
            end
            if (kill) begin
                w_out_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_out_valid_q  <= 1'b0;
                r_out_result_q <= '0;
                r_out_tag_q    <= '0;
            end else begin
                r_out_valid_q  <= w_out_valid_d;
                r_out_result_q <= w_out_result_d;
                r_out_tag_q    <= w_out_tag_d;
            end
        end

        assign out_valid  = r_out_valid_q;
        assign out_result = r_out_result_q;
        assign out_tag    = r_out_tag_q;
    end else begin : g_out_comb
        assign out_valid  = r_v2_q;
        assign out_result = w_result;
        assign out_tag    = r_tag2_q;
    end

endmodule
`default_nettype wire
